// File: rtl/bisr_weight_remapper.sv
// bisr_weight_remapper
// BISR weight allocator for the systolic array. Holds a per-PE fault map for every physical
// row, accepts one weight tile row by row and places each logical row on the lowest free
// physical row whose faulty PEs only line up with zero weights. After a complete tile it
// serves the remapped weights, physical row index and PE-disable mask.
//
// Optional feature: define BISR_SPARE_ROW_EN to add SPARE_ROWS spare physical rows that
// join the first-fit search after the regular rows.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   map_wr_en/addr/data         fault-map row write (1 = faulty PE), ignored while allocating
//   start                       begin (or restart) allocation of a new tile
//   w_valid/w_ready/w_data      weight row handshake, PE0 in the LSBs
//   rd_en/rd_addr               readout request by logical row (DONE only)
//   rd_valid/rd_phys/rd_weights/rd_pe_disable  registered readout
//   busy/done/fail/fail_row     allocation status
module bisr_weight_remapper #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned SPARE_ROWS   = 2,
`ifdef BISR_SPARE_ROW_EN
  localparam int unsigned PHYS_ROWS   = ROWS + SPARE_ROWS,
`else
  // SPARE_ROWS stays in the parameter list so both builds share one instantiation.
  localparam int unsigned PHYS_ROWS   = ROWS + 0 * SPARE_ROWS,
`endif
  localparam int unsigned LAW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned PAW         = (PHYS_ROWS > 1) ? $clog2(PHYS_ROWS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         map_wr_en,
  input  logic [PAW-1:0]               map_wr_addr,
  input  logic [COLS-1:0]              map_wr_data,
  input  logic                         start,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [COLS*WEIGHT_WIDTH-1:0] w_data,
  input  logic                         rd_en,
  input  logic [LAW-1:0]               rd_addr,
  output logic                         rd_valid,
  output logic [PAW-1:0]               rd_phys,
  output logic [COLS*WEIGHT_WIDTH-1:0] rd_weights,
  output logic [COLS-1:0]              rd_pe_disable,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [LAW-1:0]               fail_row
);

  localparam int unsigned DW = COLS * WEIGHT_WIDTH;

  typedef enum logic [1:0] {StIdle, StAlloc, StDone, StFail} state_e;

  state_e                state_q, state_d;
  logic [COLS-1:0]       fault_q [PHYS_ROWS];
  logic [COLS-1:0]       fault_d [PHYS_ROWS];
  logic [DW-1:0]         wmem_q  [PHYS_ROWS];
  logic [DW-1:0]         wmem_d  [PHYS_ROWS];
  logic [PAW-1:0]        map_q   [ROWS];
  logic [PAW-1:0]        map_d   [ROWS];
  logic [PHYS_ROWS-1:0]  used_q, used_d;
  logic [LAW-1:0]        cnt_q, cnt_d;
  logic [LAW-1:0]        fail_row_q, fail_row_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [PAW-1:0]        rd_phys_q, rd_phys_d;
  logic [DW-1:0]         rd_weights_q, rd_weights_d;
  logic [COLS-1:0]       rd_pe_disable_q, rd_pe_disable_d;

  logic                  map_addr_ok;
  logic                  rd_addr_ok;
  logic [COLS-1:0]       nz;
  logic                  found;
  logic [PAW-1:0]        win;
  logic                  accept;

  // Address range checks collapse to constants when the address space is fully populated.
  if (PHYS_ROWS == (1 << PAW)) begin : g_map_full
    assign map_addr_ok = 1'b1;
  end else begin : g_map_part
    assign map_addr_ok = int'(map_wr_addr) < int'(PHYS_ROWS);
  end

  if (ROWS == (1 << LAW)) begin : g_rd_full
    assign rd_addr_ok = 1'b1;
  end else begin : g_rd_part
    assign rd_addr_ok = int'(rd_addr) < int'(ROWS);
  end

  // First-fit search: a free row fits when every faulty PE carries a zero weight.
  always_comb begin
    for (int c = 0; c < int'(COLS); c++) begin
      nz[c] = |w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    found = 1'b0;
    win   = '0;
    for (int p = 0; p < int'(PHYS_ROWS); p++) begin
      if (!found && !used_q[p] && ((fault_q[p] & nz) == '0)) begin
        found = 1'b1;
        win   = PAW'(p);
      end
    end
  end

  // start takes priority over a beat arriving in the same cycle.
  assign accept = (state_q == StAlloc) && w_valid && !start;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    wmem_d     = wmem_q;
    map_d      = map_q;
    used_d     = used_q;
    cnt_d      = cnt_q;
    fail_row_d = fail_row_q;

    if (map_wr_en && (state_q != StAlloc) && map_addr_ok) begin
      fault_d[map_wr_addr] = map_wr_data;
    end

    if (start) begin
      state_d    = StAlloc;
      used_d     = '0;
      cnt_d      = '0;
      fail_row_d = '0;
    end else if (accept) begin
      if (found) begin
        wmem_d[win]  = w_data;
        map_d[cnt_q] = win;
        used_d[win]  = 1'b1;
        cnt_d        = cnt_q + LAW'(1);
        if (cnt_q == LAW'(ROWS - 1)) begin
          state_d = StDone;
        end
      end else begin
        fail_row_d = cnt_q;
        state_d    = StFail;
      end
    end
  end

  // Readout: data registers hold their last value, rd_valid pulses once per request.
  always_comb begin
    rd_valid_d      = 1'b0;
    rd_phys_d       = rd_phys_q;
    rd_weights_d    = rd_weights_q;
    rd_pe_disable_d = rd_pe_disable_q;
    if ((state_q == StDone) && rd_en && !start && rd_addr_ok) begin
      rd_valid_d      = 1'b1;
      rd_phys_d       = map_q[rd_addr];
      rd_weights_d    = wmem_q[map_q[rd_addr]];
      rd_pe_disable_d = fault_q[map_q[rd_addr]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      used_q          <= '0;
      cnt_q           <= '0;
      fail_row_q      <= '0;
      rd_valid_q      <= 1'b0;
      rd_phys_q       <= '0;
      rd_weights_q    <= '0;
      rd_pe_disable_q <= '0;
      for (int p = 0; p < int'(PHYS_ROWS); p++) begin
        fault_q[p] <= '0;
        wmem_q[p]  <= '0;
      end
      for (int r = 0; r < int'(ROWS); r++) begin
        map_q[r] <= '0;
      end
    end else begin
      state_q         <= state_d;
      fault_q         <= fault_d;
      wmem_q          <= wmem_d;
      map_q           <= map_d;
      used_q          <= used_d;
      cnt_q           <= cnt_d;
      fail_row_q      <= fail_row_d;
      rd_valid_q      <= rd_valid_d;
      rd_phys_q       <= rd_phys_d;
      rd_weights_q    <= rd_weights_d;
      rd_pe_disable_q <= rd_pe_disable_d;
    end
  end

  assign w_ready       = (state_q == StAlloc);
  assign busy          = (state_q == StAlloc);
  assign done          = (state_q == StDone);
  assign fail          = (state_q == StFail);
  assign fail_row      = fail_row_q;
  assign rd_valid      = rd_valid_q;
  assign rd_phys       = rd_phys_q;
  assign rd_weights    = rd_weights_q;
  assign rd_pe_disable = rd_pe_disable_q;

endmodule

// File: tb/tb_bisr_weight_remapper.sv
`timescale 1ns/1ps
module tb_bisr_weight_remapper;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int WW    = 8;
  localparam int SPARE = 2;
`ifdef BISR_SPARE_ROW_EN
  localparam int PHYS  = ROWS + SPARE;
`else
  localparam int PHYS  = ROWS;
`endif
  localparam int LAW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PAW   = (PHYS > 1) ? $clog2(PHYS) : 1;
  localparam int DW    = COLS * WW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            map_wr_en = 1'b0;
  logic [PAW-1:0]  map_wr_addr = '0;
  logic [COLS-1:0] map_wr_data = '0;
  logic            start = 1'b0;
  logic            w_valid = 1'b0;
  logic            w_ready;
  logic [DW-1:0]   w_data = '0;
  logic            rd_en = 1'b0;
  logic [LAW-1:0]  rd_addr = '0;
  logic            rd_valid;
  logic [PAW-1:0]  rd_phys;
  logic [DW-1:0]   rd_weights;
  logic [COLS-1:0] rd_pe_disable;
  logic            busy, done, fail;
  logic [LAW-1:0]  fail_row;

  bisr_weight_remapper #(
    .ROWS(ROWS), .COLS(COLS), .WEIGHT_WIDTH(WW), .SPARE_ROWS(SPARE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
    .start(start), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_phys(rd_phys),
    .rd_weights(rd_weights), .rd_pe_disable(rd_pe_disable),
    .busy(busy), .done(done), .fail(fail), .fail_row(fail_row)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: fault map, tile and expected placement.
  logic [COLS-1:0] fault_m [PHYS];
  logic [DW-1:0]   tile    [ROWS];
  int              exp_map [ROWS];
  bit              exp_fail;
  int              exp_fail_row;

  // Observations captured by the drivers.
  bit              obs_done, obs_fail, obs_ready, obs_busy;
  int              obs_fail_row, obs_lat;
  bit              obs_rdv  [ROWS];
  int              obs_phys [ROWS];
  logic [DW-1:0]   obs_w    [ROWS];
  logic [COLS-1:0] obs_dis  [ROWS];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // First-fit placement: each logical row takes the lowest unused physical row whose
  // faulty PEs only meet zero weights.
  task automatic model_alloc();
    bit              used [PHYS];
    logic [COLS-1:0] need;
    int              pick;
    for (int p = 0; p < PHYS; p++) used[p] = 1'b0;
    exp_fail = 1'b0;
    exp_fail_row = 0;
    for (int r = 0; r < ROWS; r++) begin
      pick = -1;
      for (int c = 0; c < COLS; c++) need[c] = (tile[r][c*WW +: WW] != 0);
      for (int p = 0; p < PHYS; p++)
        if (pick < 0 && !used[p] && ((fault_m[p] & need) == 0)) pick = p;
      if (pick < 0) begin
        exp_fail = 1'b1;
        exp_fail_row = r;
        return;
      end
      used[pick] = 1'b1;
      exp_map[r] = pick;
    end
  endtask

  task automatic write_faults();
    for (int p = 0; p < PHYS; p++) begin
      map_wr_en = 1'b1;
      map_wr_addr = PAW'(p);
      map_wr_data = fault_m[p];
      cyc();
    end
    map_wr_en = 1'b0;
  endtask

  task automatic fill_nonzero();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tile[r][c*WW +: WW] = 8'($urandom_range(255, 1));
  endtask

  task automatic drive_tile(input int gap_pct);
    int r;
    int guard;
    bit acc;
    start = 1'b1;
    cyc();
    start = 1'b0;
    obs_lat = 1;
    r = 0;
    guard = 0;
    while (r < ROWS && !fail && guard < 400) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        w_valid = 1'b0;
      end else begin
        w_valid = 1'b1;
        w_data = tile[r];
      end
      acc = w_valid && w_ready;
      cyc();
      obs_lat++;
      guard++;
      if (acc) r++;
    end
    w_valid = 1'b0;
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d beats, required %0d", r, ROWS);
    end
    obs_done = done;
    obs_fail = fail;
    obs_fail_row = int'(fail_row);
    obs_ready = w_ready;
    obs_busy = busy;
  endtask

  task automatic read_all();
    for (int r = 0; r < ROWS; r++) begin
      rd_en = 1'b1;
      rd_addr = LAW'(r);
      cyc();
      obs_rdv[r] = rd_valid;
      obs_phys[r] = int'(rd_phys);
      obs_w[r] = rd_weights;
      obs_dis[r] = rd_pe_disable;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({w_ready, rd_valid, busy, done, fail} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {w_ready, rd_valid, busy, done, fail});
    end
    checks++;
    if (rd_phys !== '0 || rd_weights !== '0 || rd_pe_disable !== '0 || fail_row !== '0) begin
      errors++;
      $display("FAIL reset_data: got p=%0d w=%h d=%b fr=%0d required all zero",
               rd_phys, rd_weights, rd_pe_disable, fail_row);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_healthy();
    for (int p = 0; p < PHYS; p++) fault_m[p] = '0;
    write_faults();
    fill_nonzero();
    model_alloc();
    drive_tile(0);
    checks++;
    if (!obs_done || obs_fail || obs_lat != ROWS + 1 || obs_ready || obs_busy) begin
      errors++;
      $display("FAIL healthy_done: got done=%0b fail=%0b lat=%0d rdy=%0b busy=%0b required 1 0 %0d 0 0",
               obs_done, obs_fail, obs_lat, obs_ready, obs_busy, ROWS + 1);
    end
    read_all();
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (obs_rdv[r] !== 1'b1 || obs_phys[r] != exp_map[r] || obs_w[r] !== tile[r] ||
          obs_dis[r] !== fault_m[exp_map[r]]) begin
        errors++;
        $display("FAIL healthy_read[%0d]: got v=%0b p=%0d w=%h d=%b required v=1 p=%0d w=%h d=%b",
                 r, obs_rdv[r], obs_phys[r], obs_w[r], obs_dis[r], exp_map[r], tile[r],
                 fault_m[exp_map[r]]);
      end
    end
    cyc();
    checks++;
    if (rd_valid !== 1'b0 || rd_phys !== PAW'(exp_map[ROWS-1])) begin
      errors++;
      $display("FAIL rd_pulse_hold: got v=%0b p=%0d required v=0 p=%0d",
               rd_valid, rd_phys, exp_map[ROWS-1]);
    end
  endtask

  task automatic test_zero_hide();
    for (int p = 0; p < PHYS; p++) fault_m[p] = '0;
    fault_m[0] = 4'b0001;
    write_faults();
    fill_nonzero();
    for (int r = 1; r < ROWS; r++) tile[r][WW-1:0] = '0;
    model_alloc();
    drive_tile(0);
    checks++;
    if (!obs_done || obs_fail) begin
      errors++;
      $display("FAIL zero_hide_done: got done=%0b fail=%0b required 1 0", obs_done, obs_fail);
    end
    read_all();
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (obs_rdv[r] !== 1'b1 || obs_phys[r] != exp_map[r] || obs_w[r] !== tile[r] ||
          obs_dis[r] !== fault_m[exp_map[r]]) begin
        errors++;
        $display("FAIL zero_hide_read[%0d]: got v=%0b p=%0d d=%b required v=1 p=%0d d=%b",
                 r, obs_rdv[r], obs_phys[r], obs_dis[r], exp_map[r], fault_m[exp_map[r]]);
      end
    end
  endtask

  task automatic test_fail();
    for (int p = 0; p < PHYS; p++) fault_m[p] = '0;
    fault_m[0] = 4'b0001;
    fault_m[1] = 4'b0010;
`ifdef BISR_SPARE_ROW_EN
    for (int p = ROWS; p < PHYS; p++) fault_m[p] = 4'b0100;
`endif
    write_faults();
    fill_nonzero();
    model_alloc();
    drive_tile(0);
    checks++;
    if (!obs_fail || obs_done || obs_fail_row != exp_fail_row || obs_ready || obs_busy) begin
      errors++;
      $display("FAIL fail_status: got fail=%0b done=%0b row=%0d rdy=%0b busy=%0b required 1 0 %0d 0 0",
               obs_fail, obs_done, obs_fail_row, obs_ready, obs_busy, exp_fail_row);
    end
    read_all();
    checks++;
    if (obs_rdv[0] || obs_rdv[ROWS-1]) begin
      errors++;
      $display("FAIL fail_read_ignored: got rd_valid=%0b/%0b required 0/0",
               obs_rdv[0], obs_rdv[ROWS-1]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      for (int p = 0; p < PHYS; p++)
        for (int c = 0; c < COLS; c++) fault_m[p][c] = ($urandom_range(99) < 15);
      write_faults();
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          tile[r][c*WW +: WW] = ($urandom_range(99) < 35) ? 8'h00 : 8'($urandom_range(255, 1));
      model_alloc();
      drive_tile(30);
      checks++;
      if (obs_fail != exp_fail || obs_done == exp_fail ||
          (exp_fail && obs_fail_row != exp_fail_row)) begin
        errors++;
        $display("FAIL random_status[%0d]: got fail=%0b done=%0b row=%0d required fail=%0b row=%0d",
                 it, obs_fail, obs_done, obs_fail_row, exp_fail, exp_fail_row);
      end
      read_all();
      for (int r = 0; r < ROWS; r++) begin
        checks++;
        if (exp_fail ? (obs_rdv[r] !== 1'b0) :
            (obs_rdv[r] !== 1'b1 || obs_phys[r] != exp_map[r] || obs_w[r] !== tile[r] ||
             obs_dis[r] !== fault_m[exp_map[r]])) begin
          errors++;
          $display("FAIL random_read[%0d][%0d]: got v=%0b p=%0d w=%h d=%b required fail=%0b p=%0d w=%h",
                   it, r, obs_rdv[r], obs_phys[r], obs_w[r], obs_dis[r], exp_fail,
                   exp_fail ? 0 : exp_map[r], tile[r]);
        end
      end
    end
  endtask

  task automatic test_restart();
    for (int p = 0; p < PHYS; p++) fault_m[p] = '0;
    write_faults();
    fill_nonzero();
    start = 1'b1;
    cyc();
    start = 1'b0;
    w_valid = 1'b1;
    w_data = tile[0];
    cyc();
    // Fault-map write during allocation must be dropped.
    map_wr_en = 1'b1;
    map_wr_addr = '0;
    map_wr_data = '1;
    w_data = tile[1];
    cyc();
    map_wr_en = 1'b0;
    w_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_midway: got busy=%0b done=%0b required 1 0", busy, done);
    end
    model_alloc();
    drive_tile(0);
    checks++;
    if (!obs_done || obs_fail || obs_lat != ROWS + 1) begin
      errors++;
      $display("FAIL restart_done: got done=%0b fail=%0b lat=%0d required 1 0 %0d",
               obs_done, obs_fail, obs_lat, ROWS + 1);
    end
    read_all();
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (obs_rdv[r] !== 1'b1 || obs_phys[r] != exp_map[r] || obs_w[r] !== tile[r] ||
          obs_dis[r] !== fault_m[exp_map[r]]) begin
        errors++;
        $display("FAIL restart_read[%0d]: got v=%0b p=%0d d=%b required v=1 p=%0d d=%b",
                 r, obs_rdv[r], obs_phys[r], obs_dis[r], exp_map[r], fault_m[exp_map[r]]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < PHYS; p++) fault_m[p] = 4'b0100;
    write_faults();
    rd_en = 1'b1;
    rd_addr = LAW'(1);
    cyc();
    rd_en = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    w_valid = 1'b1;
    w_data = '0;
    cyc();
    cyc();
    w_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w_ready, rd_valid, busy, done, fail} !== 5'b0 || rd_phys !== '0 ||
        rd_weights !== '0 || rd_pe_disable !== '0 || fail_row !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got flags=%b p=%0d w=%h d=%b fr=%0d required all zero",
               {w_ready, rd_valid, busy, done, fail}, rd_phys, rd_weights, rd_pe_disable, fail_row);
    end
    cyc();
    rst_n = 1'b1;
    for (int p = 0; p < PHYS; p++) fault_m[p] = '0;
    rd_en = 1'b1;
    rd_addr = LAW'(1);
    cyc();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got rd_valid=%0b required 0", rd_valid);
    end
    // Fault map must have been cleared: a dense tile now fits without failure.
    fill_nonzero();
    model_alloc();
    drive_tile(0);
    read_all();
    checks++;
    if (!obs_done || obs_phys[0] != exp_map[0] || obs_dis[0] !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_cleared: got done=%0b p=%0d d=%b required 1 %0d 0000",
               obs_done, obs_phys[0], obs_dis[0], exp_map[0]);
    end
  endtask

`ifdef BISR_SPARE_ROW_EN
  task automatic test_spare();
    for (int p = 0; p < PHYS; p++) fault_m[p] = '0;
    fault_m[0] = 4'b1000;
    write_faults();
    fill_nonzero();
    model_alloc();
    drive_tile(0);
    checks++;
    if (!obs_done || obs_fail) begin
      errors++;
      $display("FAIL spare_done: got done=%0b fail=%0b required 1 0", obs_done, obs_fail);
    end
    read_all();
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (obs_rdv[r] !== 1'b1 || obs_phys[r] != exp_map[r] || obs_w[r] !== tile[r]) begin
        errors++;
        $display("FAIL spare_read[%0d]: got v=%0b p=%0d required v=1 p=%0d",
                 r, obs_rdv[r], obs_phys[r], exp_map[r]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_healthy();
    test_zero_hide();
    test_fail();
    test_random();
    test_restart();
    test_reset_mid();
`ifdef BISR_SPARE_ROW_EN
    test_spare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
